// File: rtl/wasm_prog_loader_if.sv
// Loader-side bus of the WASM program loader: byte stream in, instruction-memory
// writes out, core reset/status handshake, and run result.
interface wasm_prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              i_start;
    logic              i_byte_valid;
    logic [7:0]        i_byte_data;
    logic              i_byte_last;
    logic              o_byte_ready;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_wdata;
    logic              o_cpu_rst_n;
    logic              i_instr_finish;
    logic              i_instr_error;
    logic              i_stack_exceed;
    logic              i_stack_empty_pop;
    logic              o_done;
    logic [2:0]        o_status;
    logic [31:0]       o_cycle_cnt;
    logic [ADDR_W:0]   o_byte_cnt;

    // The loader itself
    modport slave (
        input  i_start, i_byte_valid, i_byte_data, i_byte_last,
        input  i_instr_finish, i_instr_error, i_stack_exceed, i_stack_empty_pop,
        output o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_rst_n,
        output o_done, o_status, o_cycle_cnt, o_byte_cnt
    );

    // Host/core side driving the loader
    modport master (
        output i_start, i_byte_valid, i_byte_data, i_byte_last,
        output i_instr_finish, i_instr_error, i_stack_exceed, i_stack_empty_pop,
        input  o_byte_ready, o_mem_we, o_mem_addr, o_mem_wdata, o_cpu_rst_n,
        input  o_done, o_status, o_cycle_cnt, o_byte_cnt
    );
endinterface

// File: rtl/wasm_prog_loader.sv
// Streams a program into instruction memory, holds the WASM core in reset for
// RST_CYC cycles, then runs it until a status event or timeout and reports the result.
module wasm_prog_loader #(
    parameter int ADDR_W  = 10,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 500
) (
    input  logic              i_clk,
    input  logic              i_rst,
    wasm_prog_loader_if.slave bus
);
    localparam int                HOLD_W    = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYC - 1);
    localparam logic [31:0]       CYC_LAST  = 32'(TIMEOUT - 1);

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_FINISH  = 3'd1;
    localparam logic [2:0] ST_ERROR   = 3'd2;
    localparam logic [2:0] ST_EXCEED  = 3'd3;
    localparam logic [2:0] ST_POP     = 3'd4;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;
    localparam logic [2:0] ST_OVERFLW = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HOLD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_rst_n;
    logic              done;
    logic [2:0]        status;
    logic [31:0]       cycle_cnt;
    logic [ADDR_W:0]   byte_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic accept;
    logic addr_full;
    logic any_stat;

    // Core faults outrank a clean finish when several arrive together
    function automatic logic [2:0] run_status(input logic err, input logic exc,
                                              input logic pop, input logic fin);
        if (err)      return ST_ERROR;
        else if (exc) return ST_EXCEED;
        else if (pop) return ST_POP;
        else if (fin) return ST_FINISH;
        else          return ST_NONE;
    endfunction

    assign accept    = (state == S_LOAD) && bus.i_byte_valid && byte_ready;
    assign addr_full = &byte_cnt[ADDR_W-1:0];
    assign any_stat  = bus.i_instr_error | bus.i_stack_exceed |
                       bus.i_stack_empty_pop | bus.i_instr_finish;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.i_start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (accept) begin
                    if (bus.i_byte_last)  state_nxt = S_HOLD;
                    else if (addr_full)   state_nxt = S_DONE;
                end
            end
            S_HOLD: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            S_RUN:  if (any_stat || (cycle_cnt == CYC_LAST)) state_nxt = S_DONE;
            S_DONE: if (bus.i_start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs: level outputs follow the state being entered
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            status     <= ST_NONE;
            cycle_cnt  <= '0;
            byte_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            byte_ready <= (state_nxt == S_LOAD);
            cpu_rst_n  <= (state_nxt == S_RUN);
            done       <= (state_nxt == S_DONE);
            mem_we     <= accept;
            hold_cnt   <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;

            if (accept) begin
                mem_addr  <= byte_cnt[ADDR_W-1:0];
                mem_wdata <= bus.i_byte_data;
                byte_cnt  <= byte_cnt + 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.i_start) begin
                        byte_cnt  <= '0;
                        cycle_cnt <= '0;
                        status    <= ST_NONE;
                    end
                end
                S_LOAD: begin
                    if (accept && !bus.i_byte_last && addr_full) status <= ST_OVERFLW;
                end
                S_RUN: begin
                    if (any_stat) begin
                        status <= run_status(bus.i_instr_error, bus.i_stack_exceed,
                                             bus.i_stack_empty_pop, bus.i_instr_finish);
                    end else begin
                        cycle_cnt <= cycle_cnt + 32'd1;
                        if (cycle_cnt == CYC_LAST) status <= ST_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_byte_ready = byte_ready;
    assign bus.o_mem_we     = mem_we;
    assign bus.o_mem_addr   = mem_addr;
    assign bus.o_mem_wdata  = mem_wdata;
    assign bus.o_cpu_rst_n  = cpu_rst_n;
    assign bus.o_done       = done;
    assign bus.o_status     = status;
    assign bus.o_cycle_cnt  = cycle_cnt;
    assign bus.o_byte_cnt   = byte_cnt;
endmodule

// File: tb/tb_wasm_prog_loader.sv
// Directed bench for wasm_prog_loader: a default instance plus an ADDR_W=2
// instance for the memory-full cases.
module tb_wasm_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wasm_prog_loader_if #(.ADDR_W(10)) lb ();
    wasm_prog_loader_if #(.ADDR_W(2))  sb ();

    wasm_prog_loader #(.ADDR_W(10), .RST_CYC(2), .TIMEOUT(500)) dut (
        .i_clk(clk), .i_rst(rst), .bus(lb)
    );
    wasm_prog_loader #(.ADDR_W(2), .RST_CYC(2), .TIMEOUT(500)) dut_s (
        .i_clk(clk), .i_rst(rst), .bus(sb)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Write logs, sampled on the falling edge
    logic [9:0] wr_a [256];
    logic [7:0] wr_d [256];
    int         wr_total = 0;
    logic [1:0] sw_a [64];
    logic [7:0] sw_d [64];
    int         sw_total = 0;
    int         s_hi_total = 0;

    always @(negedge clk) begin
        if (lb.o_mem_we === 1'b1) begin
            if (wr_total < 256) begin
                wr_a[wr_total] <= lb.o_mem_addr;
                wr_d[wr_total] <= lb.o_mem_wdata;
            end
            wr_total <= wr_total + 1;
        end
        if (sb.o_mem_we === 1'b1) begin
            if (sw_total < 64) begin
                sw_a[sw_total] <= sb.o_mem_addr;
                sw_d[sw_total] <= sb.o_mem_wdata;
            end
            sw_total <= sw_total + 1;
        end
        if (sb.o_cpu_rst_n === 1'b1) s_hi_total <= s_hi_total + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_big();
        lb.i_start = 1'b1;
        tick();
        lb.i_start = 1'b0;
    endtask

    task automatic drive_byte_big(input logic [7:0] d, input logic last);
        lb.i_byte_valid = 1'b1;
        lb.i_byte_data  = d;
        lb.i_byte_last  = last;
        tick();
        lb.i_byte_valid = 1'b0;
        lb.i_byte_last  = 1'b0;
    endtask

    task automatic wait_run_big(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (lb.o_cpu_rst_n === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_tests++;
        if ({lb.o_byte_ready, lb.o_mem_we, lb.o_mem_addr, lb.o_mem_wdata, lb.o_cpu_rst_n,
             lb.o_done, lb.o_status, lb.o_cycle_cnt, lb.o_byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_big: got ready=%b we=%b addr=%0h wdata=%0h rstn=%b done=%b st=%0d cyc=%0d bc=%0d, required all 0",
                     lb.o_byte_ready, lb.o_mem_we, lb.o_mem_addr, lb.o_mem_wdata, lb.o_cpu_rst_n,
                     lb.o_done, lb.o_status, lb.o_cycle_cnt, lb.o_byte_cnt);
        end
        n_tests++;
        if ({sb.o_byte_ready, sb.o_mem_we, sb.o_mem_addr, sb.o_mem_wdata, sb.o_cpu_rst_n,
             sb.o_done, sb.o_status, sb.o_cycle_cnt, sb.o_byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_small: some output nonzero (st=%0d bc=%0d rstn=%b), required all 0",
                     sb.o_status, sb.o_byte_cnt, sb.o_cpu_rst_n);
        end
        rst = 1'b0;
        tick();
        tick();
        n_tests++;
        if (lb.o_byte_ready !== 1'b0 || lb.o_cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_outputs: got ready=%b rstn=%b, required 0 0", lb.o_byte_ready, lb.o_cpu_rst_n);
        end
    endtask

    task automatic test_load_run();
        logic [7:0] exp_d [4];
        int base;
        int low;
        exp_d = '{8'h41, 8'h20, 8'h6A, 8'h0B};
        base = wr_total;
        pulse_start_big();
        n_tests++;
        if (lb.o_byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL load_ready: got %b required 1", lb.o_byte_ready);
        end
        for (int i = 0; i < 4; i++) drive_byte_big(exp_d[i], i == 3);
        n_tests++;
        if (lb.o_byte_ready !== 1'b0 || lb.o_mem_we !== 1'b1 || lb.o_mem_addr !== 10'd3) begin
            n_fail++;
            $display("FAIL last_byte: got ready=%b we=%b addr=%0d required 0 1 3",
                     lb.o_byte_ready, lb.o_mem_we, lb.o_mem_addr);
        end
        low = 1;
        for (int i = 0; i < 20 && lb.o_cpu_rst_n !== 1'b1; i++) begin
            tick();
            if (lb.o_cpu_rst_n !== 1'b1) low++;
        end
        n_tests++;
        if (low != 2) begin
            n_fail++;
            $display("FAIL hold_len: got %0d cycles required 2", low);
        end
        n_tests++;
        if (lb.o_cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL run_start_cnt: got %0d required 0", lb.o_cycle_cnt);
        end
        repeat (9) tick();
        lb.i_instr_finish = 1'b1;
        tick();
        lb.i_instr_finish = 1'b0;
        n_tests++;
        if (lb.o_done !== 1'b1 || lb.o_status !== 3'd1 || lb.o_cycle_cnt !== 32'd9 ||
            lb.o_cpu_rst_n !== 1'b0 || lb.o_byte_cnt !== 11'd4) begin
            n_fail++;
            $display("FAIL finish_result: got done=%b st=%0d cyc=%0d rstn=%b bc=%0d required 1 1 9 0 4",
                     lb.o_done, lb.o_status, lb.o_cycle_cnt, lb.o_cpu_rst_n, lb.o_byte_cnt);
        end
        n_tests++;
        if (wr_total - base != 4) begin
            n_fail++;
            $display("FAIL write_count: got %0d required 4", wr_total - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (wr_a[base+i] !== 10'(i) || wr_d[base+i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL write_%0d: got addr=%0d data=%0h required addr=%0d data=%0h",
                             i, wr_a[base+i], wr_d[base+i], i, exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_valid_toggle();
        int base;
        bit ok;
        base = wr_total;
        pulse_start_big();
        for (int i = 0; i < 6; i++) begin
            lb.i_byte_valid = (i % 2 == 0);
            lb.i_byte_data  = 8'(8'h11 * (i / 2 + 1));
            lb.i_byte_last  = (i == 4);
            tick();
        end
        lb.i_byte_valid = 1'b0;
        lb.i_byte_last  = 1'b0;
        tick();
        n_tests++;
        if (wr_total - base != 3 || lb.o_byte_cnt !== 11'd3) begin
            n_fail++;
            $display("FAIL toggle_count: got writes=%0d bc=%0d required 3 3", wr_total - base, lb.o_byte_cnt);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (wr_a[base+i] !== 10'(i) || wr_d[base+i] !== 8'(8'h11 * (i + 1))) begin
                    n_fail++;
                    $display("FAIL toggle_write_%0d: got addr=%0d data=%0h required addr=%0d data=%0h",
                             i, wr_a[base+i], wr_d[base+i], i, 8'(8'h11 * (i + 1)));
                end
            end
        end
        wait_run_big(ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL toggle_run: got rstn=%b required 1 within bound", lb.o_cpu_rst_n);
        end
        lb.i_stack_exceed = 1'b1;
        tick();
        lb.i_stack_exceed = 1'b0;
        n_tests++;
        if (lb.o_status !== 3'd3 || lb.o_cycle_cnt !== 32'd0 || lb.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL exceed_status: got st=%0d cyc=%0d done=%b required 3 0 1",
                     lb.o_status, lb.o_cycle_cnt, lb.o_done);
        end
    endtask

    task automatic test_priority();
        bit ok;
        pulse_start_big();
        n_tests++;
        if (lb.o_status !== 3'd0 || lb.o_done !== 1'b0 || lb.o_byte_cnt !== 11'd0) begin
            n_fail++;
            $display("FAIL restart_clear: got st=%0d done=%b bc=%0d required 0 0 0",
                     lb.o_status, lb.o_done, lb.o_byte_cnt);
        end
        drive_byte_big(8'h0B, 1'b1);
        wait_run_big(ok);
        lb.i_instr_error  = 1'b1;
        lb.i_instr_finish = 1'b1;
        tick();
        lb.i_instr_error  = 1'b0;
        lb.i_instr_finish = 1'b0;
        n_tests++;
        if (!ok || lb.o_status !== 3'd2) begin
            n_fail++;
            $display("FAIL prio_error: got st=%0d run=%0d required 2 1", lb.o_status, ok);
        end

        pulse_start_big();
        drive_byte_big(8'h0B, 1'b1);
        wait_run_big(ok);
        lb.i_stack_exceed    = 1'b1;
        lb.i_stack_empty_pop = 1'b1;
        lb.i_instr_finish    = 1'b1;
        tick();
        lb.i_stack_exceed = 1'b0;
        n_tests++;
        if (!ok || lb.o_status !== 3'd3) begin
            n_fail++;
            $display("FAIL prio_exceed: got st=%0d run=%0d required 3 1", lb.o_status, ok);
        end
        lb.i_stack_empty_pop = 1'b0;
        lb.i_instr_finish    = 1'b0;

        pulse_start_big();
        drive_byte_big(8'h0B, 1'b1);
        wait_run_big(ok);
        lb.i_stack_empty_pop = 1'b1;
        lb.i_instr_finish    = 1'b1;
        tick();
        lb.i_stack_empty_pop = 1'b0;
        n_tests++;
        if (!ok || lb.o_status !== 3'd4) begin
            n_fail++;
            $display("FAIL prio_pop: got st=%0d run=%0d required 4 1", lb.o_status, ok);
        end
        // finish still high here, now in DONE: must be ignored
        tick();
        lb.i_instr_finish = 1'b0;
        n_tests++;
        if (lb.o_status !== 3'd4 || lb.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_ignores_status: got st=%0d done=%b required 4 1", lb.o_status, lb.o_done);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        pulse_start_big();
        drive_byte_big(8'h01, 1'b1);
        wait_run_big(ok);
        repeat (100) tick();
        n_tests++;
        if (!ok || lb.o_cycle_cnt !== 32'd100) begin
            n_fail++;
            $display("FAIL run_count: got %0d required 100", lb.o_cycle_cnt);
        end
        pulse_start_big();
        n_tests++;
        if (lb.o_cpu_rst_n !== 1'b1 || lb.o_done !== 1'b0 || lb.o_cycle_cnt !== 32'd101) begin
            n_fail++;
            $display("FAIL start_in_run: got rstn=%b done=%b cyc=%0d required 1 0 101",
                     lb.o_cpu_rst_n, lb.o_done, lb.o_cycle_cnt);
        end
        for (int i = 0; i < 600 && lb.o_done !== 1'b1; i++) tick();
        n_tests++;
        if (lb.o_done !== 1'b1 || lb.o_status !== 3'd5 || lb.o_cycle_cnt !== 32'd500 ||
            lb.o_cpu_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout: got done=%b st=%0d cyc=%0d rstn=%b required 1 5 500 0",
                     lb.o_done, lb.o_status, lb.o_cycle_cnt, lb.o_cpu_rst_n);
        end
    endtask

    task automatic test_overflow();
        int base;
        int hi0;
        base = sw_total;
        hi0  = s_hi_total;
        sb.i_start = 1'b1;
        tick();
        sb.i_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sb.i_byte_valid = 1'b1;
            sb.i_byte_data  = 8'(8'hA0 + i);
            sb.i_byte_last  = 1'b0;
            tick();
        end
        sb.i_byte_valid = 1'b0;
        repeat (10) tick();
        n_tests++;
        if (sb.o_status !== 3'd6 || sb.o_byte_cnt !== 3'd4 || sb.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_status: got st=%0d bc=%0d done=%b required 6 4 1",
                     sb.o_status, sb.o_byte_cnt, sb.o_done);
        end
        n_tests++;
        if (s_hi_total != hi0) begin
            n_fail++;
            $display("FAIL overflow_core_released: got %0d high cycles required 0", s_hi_total - hi0);
        end
        n_tests++;
        if (sw_total - base != 4) begin
            n_fail++;
            $display("FAIL overflow_writes: got %0d required 4", sw_total - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (sw_a[base+i] !== 2'(i) || sw_d[base+i] !== 8'(8'hA0 + i)) begin
                    n_fail++;
                    $display("FAIL overflow_write_%0d: got addr=%0d data=%0h required addr=%0d data=%0h",
                             i, sw_a[base+i], sw_d[base+i], i, 8'(8'hA0 + i));
                end
            end
        end
    endtask

    task automatic test_full_last();
        sb.i_start = 1'b1;
        tick();
        sb.i_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.i_byte_valid = 1'b1;
            sb.i_byte_data  = 8'(8'hC0 + i);
            sb.i_byte_last  = (i == 3);
            tick();
        end
        sb.i_byte_valid = 1'b0;
        sb.i_byte_last  = 1'b0;
        for (int i = 0; i < 20 && sb.o_cpu_rst_n !== 1'b1; i++) tick();
        n_tests++;
        if (sb.o_cpu_rst_n !== 1'b1 || sb.o_status !== 3'd0 || sb.o_byte_cnt !== 3'd4) begin
            n_fail++;
            $display("FAIL full_last: got rstn=%b st=%0d bc=%0d required 1 0 4",
                     sb.o_cpu_rst_n, sb.o_status, sb.o_byte_cnt);
        end
        sb.i_instr_finish = 1'b1;
        tick();
        sb.i_instr_finish = 1'b0;
        n_tests++;
        if (sb.o_status !== 3'd1 || sb.o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL full_last_finish: got st=%0d done=%b required 1 1", sb.o_status, sb.o_done);
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int base;
        pulse_start_big();
        drive_byte_big(8'h55, 1'b0);
        drive_byte_big(8'h66, 1'b1);
        wait_run_big(ok);
        repeat (5) tick();
        n_tests++;
        if (!ok || lb.o_cycle_cnt !== 32'd5) begin
            n_fail++;
            $display("FAIL pre_reset_run: got cyc=%0d run=%0d required 5 1", lb.o_cycle_cnt, ok);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({lb.o_byte_ready, lb.o_mem_we, lb.o_mem_addr, lb.o_mem_wdata, lb.o_cpu_rst_n,
             lb.o_done, lb.o_status, lb.o_cycle_cnt, lb.o_byte_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_run_reset: got addr=%0h wdata=%0h rstn=%b st=%0d cyc=%0d bc=%0d, required all 0",
                     lb.o_mem_addr, lb.o_mem_wdata, lb.o_cpu_rst_n, lb.o_status, lb.o_cycle_cnt, lb.o_byte_cnt);
        end
        tick();
        base = wr_total;
        pulse_start_big();
        drive_byte_big(8'h7F, 1'b1);
        tick();
        n_tests++;
        if (wr_total - base != 1 || wr_a[base] !== 10'd0 || wr_d[base] !== 8'h7F) begin
            n_fail++;
            $display("FAIL reload_write: got n=%0d addr=%0d data=%0h required 1 0 7f",
                     wr_total - base, wr_a[base], wr_d[base]);
        end
        wait_run_big(ok);
        n_tests++;
        if (!ok || lb.o_cycle_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reload_cnt_start: got cyc=%0d run=%0d required 0 1", lb.o_cycle_cnt, ok);
        end
        repeat (3) tick();
        lb.i_instr_finish = 1'b1;
        tick();
        lb.i_instr_finish = 1'b0;
        n_tests++;
        if (lb.o_status !== 3'd1 || lb.o_cycle_cnt !== 32'd3 || lb.o_byte_cnt !== 11'd1) begin
            n_fail++;
            $display("FAIL reload_result: got st=%0d cyc=%0d bc=%0d required 1 3 1",
                     lb.o_status, lb.o_cycle_cnt, lb.o_byte_cnt);
        end
    endtask

    initial begin
        lb.i_start = 1'b0; lb.i_byte_valid = 1'b0; lb.i_byte_data = '0; lb.i_byte_last = 1'b0;
        lb.i_instr_finish = 1'b0; lb.i_instr_error = 1'b0;
        lb.i_stack_exceed = 1'b0; lb.i_stack_empty_pop = 1'b0;
        sb.i_start = 1'b0; sb.i_byte_valid = 1'b0; sb.i_byte_data = '0; sb.i_byte_last = 1'b0;
        sb.i_instr_finish = 1'b0; sb.i_instr_error = 1'b0;
        sb.i_stack_exceed = 1'b0; sb.i_stack_empty_pop = 1'b0;

        test_reset();
        test_load_run();
        test_valid_toggle();
        test_priority();
        test_timeout();
        test_overflow();
        test_full_last();
        test_reset_mid_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wasm_prog_loader.md
WASM_PROG_LOADER -- requirements
Module: wasm_prog_loader

Interface
REQ-001 Parameter ADDR_W, default 10: instruction-memory byte address width (depth 2^ADDR_W).
REQ-002 Parameter RST_CYC, default 2: cycles the core is held in reset between load and run.
REQ-003 Parameter TIMEOUT, default 500: maximum run cycles before abort.
REQ-004 Port i_clk  in  1: single clock; all logic on rising edge.
REQ-005 Port i_rst  in  1: synchronous, active-high reset.
REQ-006 Port i_start  in  1: one-cycle pulse starting a load; honoured only in IDLE or DONE.
REQ-007 Port i_byte_valid  in  1: program byte available.
REQ-008 Port i_byte_data  in  8: program byte.
REQ-009 Port i_byte_last  in  1: qualifies the final byte of the program.
REQ-010 Port o_byte_ready  out  1: loader accepts a byte this cycle.
REQ-011 Port o_mem_we  out  1: instruction-memory write strobe.
REQ-012 Port o_mem_addr  out  ADDR_W: write address.
REQ-013 Port o_mem_wdata  out  8: write data.
REQ-014 Port o_cpu_rst_n  out  1: active-low reset driven to the WASM core.
REQ-015 Ports i_instr_finish, i_instr_error, i_stack_exceed, i_stack_empty_pop  in  1 each: core status.
REQ-016 Port o_done  out  1: run terminated; result valid.
REQ-017 Port o_status  out  3: 0 none, 1 finish, 2 instr error, 3 stack exceed, 4 empty pop, 5 timeout, 6 load overflow.
REQ-018 Port o_cycle_cnt  out  32: run cycles counted.
REQ-019 Port o_byte_cnt  out  ADDR_W+1: bytes written in last load.

Function
REQ-020 States IDLE, LOAD, HOLD, RUN, DONE; all outputs registered.
REQ-021 IDLE: o_byte_ready=0, o_mem_we=0, o_cpu_rst_n=0; i_start -> LOAD, clearing o_byte_cnt, o_cycle_cnt, o_status, o_done.
REQ-022 LOAD: o_byte_ready=1; each cycle with i_byte_valid&o_byte_ready, next cycle o_mem_we=1, o_mem_addr=o_byte_cnt[ADDR_W-1:0], o_mem_wdata=i_byte_data, o_byte_cnt+1.
REQ-023 LOAD: o_mem_we=0 on cycles following no accepted byte; o_mem_addr/wdata hold.
REQ-024 Accepted byte with i_byte_last=1 -> HOLD; o_byte_ready=0 from next cycle.
REQ-025 Accepted byte at address 2^ADDR_W-1 with i_byte_last=0: byte written, status=6, -> DONE; core never released.
REQ-026 Accepted byte at address 2^ADDR_W-1 with i_byte_last=1: normal -> HOLD, status stays 0.
REQ-027 HOLD: o_cpu_rst_n=0 for exactly RST_CYC cycles, then -> RUN.
REQ-028 RUN: o_cpu_rst_n=1; o_cycle_cnt starts at 0, increments each RUN cycle in which no status input is sampled high.
REQ-029 RUN termination on any status input high: -> DONE, o_cycle_cnt not incremented that cycle, o_status set.
REQ-030 Simultaneous status inputs priority: instr error(2) > stack exceed(3) > empty pop(4) > finish(1).
REQ-031 RUN with o_cycle_cnt==TIMEOUT-1 and no status input: o_cycle_cnt=TIMEOUT, o_status=5, -> DONE; a status input that same cycle wins over timeout.
REQ-032 DONE: o_done=1, o_cpu_rst_n=0, counters and status hold; i_start -> LOAD (restart, clears as REQ-021).
REQ-033 i_start ignored in LOAD, HOLD, RUN; status inputs ignored outside RUN.

Reset
REQ-034 i_rst high at a clock edge -> IDLE next cycle, from any state, including mid-load or mid-run.
REQ-035 Reset values: o_byte_ready=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_cpu_rst_n=0, o_done=0, o_status=0, o_cycle_cnt=0, o_byte_cnt=0.
REQ-036 Memory contents are not cleared by reset.

Verification
REQ-037 Load 4 bytes 0x41,0x20,0x6A,0x0B (last on 4th), i_instr_finish high on 10th RUN cycle -> writes addr 0..3 in order, o_byte_cnt=4, o_cpu_rst_n low exactly 2 cycles, o_status=1, o_cycle_cnt=9, o_done=1.
REQ-038 Valid toggling 1/0 during 3-byte load -> exactly 3 o_mem_we pulses, addresses 0,1,2, no duplicates.
REQ-039 i_instr_error and i_instr_finish high together in RUN -> o_status=2.
REQ-040 No status input for whole run -> o_status=5, o_cycle_cnt=500, o_cpu_rst_n returns to 0.
REQ-041 ADDR_W=2, 5 bytes without last -> 4 writes, o_status=6, o_byte_cnt=4, o_cpu_rst_n never 1.
REQ-042 i_rst asserted mid-RUN then i_start -> all outputs at reset values, fresh load from addr 0, o_cycle_cnt restarts at 0.
